// File: rtl/mem_stage_hs_pkg.sv
// rtl/mem_stage_hs_pkg.sv - shared widths, stall encoding, mem_op one-hots and EX-to-MEM layout
package mem_stage_hs_pkg;

    localparam int STALL_W      = 6;
    localparam int EX_TO_MEM_WD = 183;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_RF_WD = 104;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall vector positions: this stage's input register and the one after it
    localparam int STALL_SELF = 3;
    localparam int STALL_NEXT = 4;

    localparam logic [7:0] OP_LB  = 8'b1000_0000;
    localparam logic [7:0] OP_LBU = 8'b0100_0000;
    localparam logic [7:0] OP_LH  = 8'b0010_0000;
    localparam logic [7:0] OP_LHU = 8'b0001_0000;
    localparam logic [7:0] OP_LW  = 8'b0000_1000;
    localparam logic [7:0] OP_SB  = 8'b0000_0100;
    localparam logic [7:0] OP_SH  = 8'b0000_0010;
    localparam logic [7:0] OP_SW  = 8'b0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [31:0] store_wdata;
        logic [7:0]  mem_op;
        logic [65:0] hilo_bus;
        logic [31:0] pc;
        logic        ram_en;
        logic        ram_wen;
        logic [3:0]  ram_sel;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_hs_load_align.sv
// rtl/mem_stage_hs_load_align.sv - picks the addressed byte/halfword of a load word and extends it
module mem_stage_hs_load_align
    import mem_stage_hs_pkg::*;
(
    input  logic [7:0]  mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (mem_op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'b0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'b0, half_sel};
            OP_LW:   data = word;
            default: data = 32'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - MEM stage owning the data bus via req/addr_ok/data_ok handshake
module mem_stage_hs
    import mem_stage_hs_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_W-1:0]      stall,
    output logic                    stallreq_for_mem,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic                    data_req,
    output logic                    data_wr,
    output logic [3:0]              data_wstrb,
    output logic [31:0]             data_addr,
    output logic [31:0]             data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [31:0]             data_rdata
);

    ex_to_mem_t  bus_q, bus_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    mem_state_e  state_q, state_d;

    logic        load_bus;
    logic        bubble;
    logic        acc_needed;
    logic        complete;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        stall_unused;

    assign stall_unused = ^{stall[5], stall[2:0]};

    always_comb begin
        load_bus   = (stall[STALL_SELF] == NO_STOP);
        bubble     = (stall[STALL_SELF] == STOP) && (stall[STALL_NEXT] == NO_STOP);
        acc_needed = bus_q.ram_en & ~done_q;
    end

    // IDLE raises the request combinationally so a zero-wait slave can accept in the same cycle
    always_comb begin
        state_d  = state_q;
        data_req = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_needed) begin
                    data_req = 1'b1;
                    state_d  = data_addr_ok ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                data_req = 1'b1;
                if (data_addr_ok) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (data_data_ok) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_d   = bus_q;
        done_d  = done_q;
        rdata_d = rdata_q;
        if (bubble) begin
            bus_d  = '0;
            done_d = 1'b0;
        end else if (load_bus) begin
            bus_d  = ex_to_mem_t'(ex_to_mem_bus);
            done_d = 1'b0;
        end else if (complete) begin
            done_d = 1'b1;
        end
        if (complete) begin
            rdata_d = data_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            bus_q   <= '0;
            done_q  <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    mem_stage_hs_load_align u_load_align (
        .mem_op (bus_q.mem_op),
        .offset (bus_q.ex_result[1:0]),
        .word   (rdata_q),
        .data   (load_data)
    );

    // Request fields come straight from bus_q, which the stall holds while data_req is up
    always_comb begin
        stallreq_for_mem = acc_needed | (state_q != ST_IDLE);
        data_wr          = bus_q.ram_wen;
        data_wstrb       = bus_q.ram_wen ? bus_q.ram_sel : 4'b0;
        data_addr        = bus_q.ex_result;
        data_wdata       = bus_q.store_wdata;
        rf_wdata         = bus_q.sel_rf_res ? load_data : bus_q.ex_result;
        mem_to_wb_bus    = {bus_q.hilo_bus, bus_q.pc, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
        mem_to_rf_bus    = {bus_q.hilo_bus, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - directed table and sequence checks for mem_stage_hs
module tb_mem_stage_hs;
    import mem_stage_hs_pkg::*;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic [STALL_W-1:0]      stall;
    logic                    stallreq_for_mem;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;
    logic                    data_req;
    logic                    data_wr;
    logic [3:0]              data_wstrb;
    logic [31:0]             data_addr;
    logic [31:0]             data_wdata;
    logic                    data_addr_ok;
    logic                    data_data_ok;
    logic [31:0]             data_rdata;

    ex_to_mem_t  ex_in;
    logic        force_en;
    logic [5:0]  force_val;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign ex_to_mem_bus = ex_in;
    assign stall = force_en ? force_val : (stallreq_for_mem ? 6'b011111 : 6'b000000);

    mem_stage_hs dut (
        .clk              (clk),
        .resetn           (resetn),
        .stall            (stall),
        .stallreq_for_mem (stallreq_for_mem),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_rf_bus    (mem_to_rf_bus),
        .data_req         (data_req),
        .data_wr          (data_wr),
        .data_wstrb       (data_wstrb),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_addr_ok     (data_addr_ok),
        .data_data_ok     (data_data_ok),
        .data_rdata       (data_rdata)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          alat;
        int          dlat;
        logic [31:0] want;
    } vec_t;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic ex_to_mem_t mk_load(input logic [7:0] op, input logic [31:0] addr);
        ex_to_mem_t b;
        b             = '0;
        b.mem_op      = op;
        b.hilo_bus    = {2'b10, 32'hCAFE_0001, 32'h1357_9BDF};
        b.pc          = 32'hBFC0_0000 + addr;
        b.ram_en      = 1'b1;
        b.ram_sel     = 4'b1111;
        b.sel_rf_res  = 1'b1;
        b.rf_we       = 1'b1;
        b.rf_waddr    = 5'd7;
        b.ex_result   = addr;
        return b;
    endfunction

    // Drives one instruction through, playing a slave with alat request-wait and dlat response-wait cycles
    task automatic run_access(input ex_to_mem_t ins, input int alat, input int dlat,
                              input logic [31:0] rdata_val,
                              output int st, output int nreq, output logic [31:0] wdata);
        int   rw;
        int   dw;
        bit   got;
        bit   r_s;
        bit   a_s;
        logic [3:0] exp_strb;
        rw = 0; dw = -1; got = 0; st = 0; nreq = 0;
        exp_strb = ins.ram_wen ? ins.ram_sel : 4'b0;
        @(posedge clk); #1 ex_in = ins;
        @(posedge clk); #1 ex_in = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            data_addr_ok = data_req && (rw == alat);
            data_data_ok = (dw == 0);
            data_rdata   = (dw == 0) ? rdata_val : 32'h0BAD_0BAD;
            @(negedge clk);
            r_s = data_req;
            a_s = data_addr_ok;
            if (stallreq_for_mem) st++;
            if (r_s && a_s) nreq++;
            if (r_s) check("req_fields", {data_addr, data_wr, data_wstrb, data_wdata},
                           {ins.ex_result, ins.ram_wen, exp_strb, ins.store_wdata});
            if (data_data_ok) got = 1;
            @(posedge clk); #1;
            if (a_s) dw = dlat - 1;
            else if (dw >= 0) dw--;
            if (r_s && !a_s) rw++;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0BAD_0BAD;
        check("access_completed", got, 1);
        @(negedge clk);
        if (stallreq_for_mem) st++;
        wdata = mem_to_wb_bus[31:0];
    endtask

    initial begin
        vec_t        vecs[9];
        ex_to_mem_t  ins;
        int          st;
        int          nreq;
        logic [31:0] wd;
        int          extra_req;

        vecs[0] = '{OP_LB,  32'h0000_0103, 32'h80FF_0000, 0, 1, 32'hFFFF_FF80};
        vecs[1] = '{OP_LBU, 32'h0000_0111, 32'h1234_8078, 0, 1, 32'h0000_0080};
        vecs[2] = '{OP_LH,  32'h0000_0120, 32'h0000_8001, 0, 1, 32'hFFFF_8001};
        vecs[3] = '{OP_LH,  32'h0000_0132, 32'h7FFF_0000, 1, 1, 32'h0000_7FFF};
        vecs[4] = '{OP_LHU, 32'h0000_0140, 32'hABCD_F00D, 0, 2, 32'h0000_F00D};
        vecs[5] = '{OP_LW,  32'h0000_0150, 32'hDEAD_BEEF, 1, 3, 32'hDEAD_BEEF};
        vecs[6] = '{OP_LB,  32'h0000_0160, 32'h0000_007F, 0, 1, 32'h0000_007F};
        vecs[7] = '{OP_LBU, 32'h0000_0172, 32'h00C3_0000, 0, 1, 32'h0000_00C3};
        vecs[8] = '{OP_LHU, 32'h0000_0102, 32'hABCD_1234, 2, 2, 32'h0000_ABCD};

        resetn = 1'b0; force_en = 1'b0; force_val = '0; ex_in = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_req", data_req, 0);
        check("reset_stallreq", stallreq_for_mem, 0);
        check("reset_wb_bus", mem_to_wb_bus, 0);
        check("reset_rf_bus", mem_to_rf_bus, 0);
        resetn = 1'b1;

        // ALU result passes through in one cycle
        ins = '0;
        ins.rf_we = 1'b1; ins.rf_waddr = 5'd5; ins.ex_result = 32'h1234; ins.pc = 32'hBFC0_0010;
        @(posedge clk); #1 ex_in = ins;
        @(posedge clk); #1 ex_in = '0;
        @(negedge clk);
        check("alu_wb_bus", mem_to_wb_bus, {66'b0, 32'hBFC0_0010, 1'b1, 5'd5, 32'h1234});
        check("alu_req", data_req, 0);
        check("alu_stallreq", stallreq_for_mem, 0);

        for (int i = 0; i < 9; i++) begin
            ins = mk_load(vecs[i].op, vecs[i].addr);
            run_access(ins, vecs[i].alat, vecs[i].dlat, vecs[i].rdata, st, nreq, wd);
            check($sformatf("row%0d_rf_wdata", i), wd, vecs[i].want);
            check($sformatf("row%0d_stall_cycles", i), st, vecs[i].alat + vecs[i].dlat + 1);
            check($sformatf("row%0d_nreq", i), nreq, 1);
            check($sformatf("row%0d_wb_bus", i), mem_to_wb_bus,
                  {ins.hilo_bus, ins.pc, 1'b1, 5'd7, vecs[i].want});
            check($sformatf("row%0d_rf_bus", i), mem_to_rf_bus,
                  {ins.hilo_bus, 1'b1, 5'd7, vecs[i].want});
        end

        // Byte store at offset 1
        ins = '0;
        ins.mem_op = OP_SB; ins.ram_en = 1'b1; ins.ram_wen = 1'b1; ins.ram_sel = 4'b0010;
        ins.ex_result = 32'h0000_0201; ins.store_wdata = 32'h5A5A_5A5A;
        run_access(ins, 1, 1, 32'h0, st, nreq, wd);
        check("sb_stall_cycles", st, 3);
        check("sb_nreq", nreq, 1);
        check("sb_rf_we", mem_to_wb_bus[37], 0);
        check("sb_rf_wdata", wd, 32'h0000_0201);

        // Downstream hold after a completed lw, then a bubble
        run_access(mk_load(OP_LW, 32'h300), 0, 1, 32'h600D_F00D, st, nreq, wd);
        check("hold_lw_data", wd, 32'h600D_F00D);
        check("hold_nreq", nreq, 1);
        force_en = 1'b1; force_val = 6'b011000;
        extra_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (data_req) extra_req++;
            check($sformatf("hold%0d_rf_wdata", k), mem_to_wb_bus[31:0], 32'h600D_F00D);
        end
        check("hold_extra_req", extra_req, 0);
        force_val = 6'b001000;
        @(negedge clk);
        check("bubble_wb_bus", mem_to_wb_bus, 0);
        force_en = 1'b0;

        // Reset asserted while waiting for data_ok
        ins = mk_load(OP_LW, 32'h400);
        @(posedge clk); #1 ex_in = ins;
        @(posedge clk); #1 ex_in = '0; data_addr_ok = 1'b1;
        @(posedge clk); #1 data_addr_ok = 1'b0;
        check("resp_stallreq", stallreq_for_mem, 1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_req", data_req, 0);
        check("midrst_stallreq", stallreq_for_mem, 0);
        check("midrst_wb_bus", mem_to_wb_bus, 0);
        check("midrst_rf_bus", mem_to_rf_bus, 0);
        @(negedge clk) resetn = 1'b1;
        run_access(mk_load(OP_LW, 32'h404), 0, 1, 32'h1111_2222, st, nreq, wd);
        check("post_rst_rf_wdata", wd, 32'h1111_2222);
        check("post_rst_stall_cycles", st, 2);
        check("post_rst_nreq", nreq, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
